// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: one-hot FSM encoding, baud constants
// and a small index-to-one-hot helper.
package uart_pkg;

   localparam int CLK_FREQ = 50_000_000;
   localparam int UART_BPS = 115_200;
   localparam int BPS_CNT  = CLK_FREQ / UART_BPS;

   localparam logic [4:0] ST_IDLE_OH      = 5'b00001;
   localparam logic [4:0] ST_LAUNCH_OH    = 5'b00010;
   localparam logic [4:0] ST_WAIT_BUSY_OH = 5'b00100;
   localparam logic [4:0] ST_WAIT_DONE_OH = 5'b01000;
   localparam logic [4:0] ST_GAP_OH       = 5'b10000;

   typedef enum logic [4:0] {
      ST_IDLE      = ST_IDLE_OH,
      ST_LAUNCH    = ST_LAUNCH_OH,
      ST_WAIT_BUSY = ST_WAIT_BUSY_OH,
      ST_WAIT_DONE = ST_WAIT_DONE_OH,
      ST_GAP       = ST_GAP_OH
   } arb_state_t;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: returns the first set bit of valid scanning upward
// from ptr+1 with wrap-around.
module uart_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] valid,
   input  logic [2:0]   ptr,
   output logic         hit,
   output logic [2:0]   idx
);

   int best_d;
   int d;

   // d is each requester's distance behind ptr; the smallest valid distance wins.
   always_comb begin
      hit    = 1'b0;
      idx    = '0;
      best_d = N;
      d      = 0;
      for (int i = 0; i < N; i++) begin
         d = (i > int'(ptr)) ? (i - int'(ptr) - 1) : (i + N - int'(ptr) - 1);
         if (valid[i] && (d < best_d)) begin
            best_d = d;
            hit    = 1'b1;
            idx    = 3'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx among N_REQ byte producers
// and sequences launch, busy handshake and the inter-byte guard gap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 8,
   parameter int GAP_CYCLES   = 16,
   parameter int CNT_W        = 16
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               uart_en,
   output logic [7:0]         uart_din,
   input  logic               uart_tx_busy,
   output logic [2:0]         grant_id,
   output logic               lock_active,
   output logic               err_timeout,
   output arb_state_t         fsm_state
);

   // Handshake: a requester offers a byte by holding req_valid with stable req_data/req_last;
   // the byte is consumed in the single cycle req_ready is high, which coincides with uart_en.

   localparam logic [CNT_W-1:0] TO_LAST  = (BUSY_TIMEOUT > 0) ? CNT_W'(BUSY_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0)   ? CNT_W'(GAP_CYCLES - 1)   : '0;

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       ptr_q;
   logic [2:0]       sel_q;
   logic [2:0]       pick_idx;
   logic             pick_hit;
   logic [N_REQ-1:0] elig;
   logic [7:0]       sel_data;
   logic             sel_last;

   // While a packet is locked only the owner is visible to the picker.
   assign elig = lock_active ? (req_valid & N_REQ'(onehot8(grant_id))) : req_valid;

   uart_rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .valid (elig),
      .ptr   (ptr_q),
      .hit   (pick_hit),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_q == 3'(i)) begin
            sel_data = req_data[8*i +: 8];
            sel_last = req_last[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!uart_tx_busy && pick_hit) state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (uart_tx_busy)            state_d = ST_WAIT_DONE;
            else if (cnt_q >= TO_LAST)   state_d = ST_GAP;
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q >= GAP_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Single shared counter: restarts on every state change, runs only where time is measured.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                                              cnt_q <= '0;
      else if (state_d != state_q)                              cnt_q <= '0;
      else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_GAP)) cnt_q <= cnt_q + 1'b1;
      else                                                      cnt_q <= '0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         req_ready   <= '0;
         uart_en     <= 1'b0;
         uart_din    <= '0;
         grant_id    <= '0;
         lock_active <= 1'b0;
         err_timeout <= 1'b0;
         ptr_q       <= 3'(N_REQ - 1);
         sel_q       <= '0;
      end else begin
         req_ready   <= '0;
         uart_en     <= 1'b0;
         err_timeout <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (state_d == ST_LAUNCH) sel_q <= pick_idx;
            end
            ST_LAUNCH: begin
               req_ready   <= N_REQ'(onehot8(sel_q));
               uart_en     <= 1'b1;
               uart_din    <= sel_data;
               grant_id    <= sel_q;
               ptr_q       <= sel_q;
               lock_active <= ~sel_last;
            end
            ST_WAIT_BUSY: begin
               // uart_tx never acknowledged: drop the byte and abandon the packet.
               if (state_d == ST_GAP) begin
                  err_timeout <= 1'b1;
                  lock_active <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fsm_state = state_q;

endmodule
